// File: rtl/edge_bram_pkg.sv
// Shared definitions for the edge/bin BRAM arbiter and its requesters.
// Frame geometry, requester indices and the read-tag carried alongside BRAM reads.
package edge_bram_pkg;

    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 3;
    localparam int WIDTH      = 640;
    localparam int HEIGHT     = 480;
    localparam int MAX_ADDR   = WIDTH * HEIGHT - 1;
    localparam int RD_LATENCY = 2;
    localparam int STARVE_MAX = 15;

    localparam logic [1:0] REQ_EDGE    = 2'd0;
    localparam logic [1:0] REQ_CONTOUR = 2'd1;
    localparam logic [1:0] REQ_DISPLAY = 2'd2;

    // Why a cycle's grant was issued; SRC_NONE means the BRAM port idles.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_RR,
        SRC_DISPLAY,
        SRC_OVERRIDE
    } grant_src_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic       oob;
    } rd_tag_t;

    function automatic logic [2:0] req_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/edge_bram_arbiter_rd_tag_pipe.sv
// Shift register of read tags that tracks each granted read through the BRAM latency.
// Asynchronous clear discards every in-flight read.
module rd_tag_pipe
    import edge_bram_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t in_tag,
    output rd_tag_t out_tag
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/edge_bram_arbiter.sv
// Arbitrates the single-port edge/bin BRAM between edge detector, contour tracer and display.
// Display has priority, bounded by a starvation counter; edge and contour alternate.
module edge_bram_arbiter
    import edge_bram_pkg::*;
#(
    parameter int ADDR_W     = edge_bram_pkg::ADDR_W,
    parameter int DATA_W     = edge_bram_pkg::DATA_W,
    parameter int RD_LATENCY = edge_bram_pkg::RD_LATENCY,
    parameter int MAX_ADDR   = edge_bram_pkg::MAX_ADDR,
    parameter int STARVE_MAX = edge_bram_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              addr_err,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic              rr_ptr;
    logic [SW-1:0]     starve_cnt;
    logic              any_low;
    logic [1:0]        rr_win;
    grant_src_e        grant_src;
    logic              granted;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_oob;
    rd_tag_t           push_tag;
    rd_tag_t           exit_tag;

    assign any_low = req[REQ_EDGE] | req[REQ_CONTOUR];

    always_comb begin
        rr_win = REQ_EDGE;
        if (rr_ptr == 1'b0) begin
            rr_win = req[REQ_EDGE] ? REQ_EDGE : REQ_CONTOUR;
        end else begin
            rr_win = req[REQ_CONTOUR] ? REQ_CONTOUR : REQ_EDGE;
        end
    end

    // Grants are suppressed while reset is high so no access can be issued during reset.
    always_comb begin
        grant_src = SRC_NONE;
        if (reset) begin
            grant_src = SRC_NONE;
        end else if (any_low && starve_cnt == SW'(STARVE_MAX)) begin
            grant_src = SRC_OVERRIDE;
        end else if (req[REQ_DISPLAY]) begin
            grant_src = SRC_DISPLAY;
        end else if (any_low) begin
            grant_src = SRC_RR;
        end
    end

    always_comb begin
        sel = REQ_EDGE;
        case (grant_src)
            SRC_OVERRIDE, SRC_RR: sel = rr_win;
            SRC_DISPLAY:          sel = REQ_DISPLAY;
            default:              sel = REQ_EDGE;
        endcase
    end

    assign granted = (grant_src != SRC_NONE);
    assign gnt     = granted ? req_onehot(sel) : 3'b000;

    always_comb begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
        sel_we    = we[0];
        case (sel)
            REQ_CONTOUR: begin
                sel_addr  = addr1;
                sel_wdata = wdata1;
                sel_we    = we[1];
            end
            REQ_DISPLAY: begin
                sel_addr  = addr2;
                sel_wdata = wdata2;
                sel_we    = we[2];
            end
            default: begin
                sel_addr  = addr0;
                sel_wdata = wdata0;
                sel_we    = we[0];
            end
        endcase
    end

    // Underflowed addresses (addr-1, addr-640) wrap high and land here as out of range.
    assign sel_oob = (sel_addr > ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (granted && sel != REQ_DISPLAY) begin
                rr_ptr <= (sel == REQ_EDGE);
            end
            if (!any_low || (granted && sel != REQ_DISPLAY)) begin
                starve_cnt <= '0;
            end else if (gnt[REQ_DISPLAY] && starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            bram_we <= granted & sel_we & ~sel_oob;
            if (granted) begin
                bram_addr <= sel_addr;
                bram_din  <= sel_wdata;
            end
            if (granted && sel_oob) begin
                addr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        push_tag       = '0;
        push_tag.valid = granted & ~sel_we;
        push_tag.idx   = sel;
        push_tag.oob   = sel_oob;
    end

    rd_tag_pipe #(
        .DEPTH (1 + RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_tag  (push_tag),
        .out_tag (exit_tag)
    );

    assign rvalid = exit_tag.valid ? req_onehot(exit_tag.idx) : 3'b000;
    assign rdata  = (exit_tag.valid && !exit_tag.oob) ? bram_dout : '0;

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Directed self-checking bench for edge_bram_arbiter with a two-cycle-latency BRAM model.
module tb_edge_bram_arbiter;
    import edge_bram_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [18:0] addr0, addr1, addr2;
    logic [2:0]  wdata0, wdata1, wdata2;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [2:0]  rdata;
    logic        addr_err;
    logic [18:0] bram_addr;
    logic [2:0]  bram_din;
    logic        bram_we;
    logic [2:0]  bram_dout;
    logic [2:0]  dout_d1;
    logic [2:0]  mem [0:524287];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_bram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .addr2     (addr2),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .wdata2    (wdata2),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout)
    );

    function automatic logic [2:0] preload(input logic [18:0] a);
        case (a)
            19'd10:    return 3'd1;
            19'd20:    return 3'd2;
            19'd641:   return 3'b101;
            19'h7FFFF: return 3'b111;
            default:   return 3'd0;
        endcase
    endfunction

    // BRAM model: address registered by the DUT, data out two edges later, read-before-write.
    initial begin
        dout_d1   = '0;
        bram_dout = '0;
        for (int i = 0; i < 524288; i++) mem[i] = preload(19'(i));
        forever begin
            @(posedge clk);
            if (bram_we) mem[bram_addr] <= bram_din;
            dout_d1   <= mem[bram_addr];
            bram_dout <= dout_d1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] w,
                                 input logic [18:0] a0, input logic [18:0] a1, input logic [18:0] a2,
                                 input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2);
        @(negedge clk);
        req = r; we = w;
        addr0 = a0; addr1 = a1; addr2 = a2;
        wdata0 = d0; wdata1 = d1; wdata2 = d2;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt", gnt, 3'b000);
        checkOutput("rst_rvalid", rvalid, 3'b000);
        checkOutput("rst_rdata", rdata, 3'd0);
        checkOutput("rst_addr_err", addr_err, 1'b0);
        checkOutput("rst_bram_addr", bram_addr, 19'd0);
        checkOutput("rst_bram_din", bram_din, 3'd0);
        checkOutput("rst_bram_we", bram_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] round-robin between edge and contour");
        for (int k = 0; k < 8; k++) begin
            applyStimulus((k < 4) ? 3'b011 : 3'b000, 3'b000, 19'd10, 19'd20, 19'd0, 3'd0, 3'd0, 3'd0);
            if (k < 4) checkOutput("rr_gnt", gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
            if (k >= 3 && k < 7) begin
                checkOutput("rr_rvalid", rvalid, ((k - 3) % 2 == 0) ? 3'b001 : 3'b010);
                checkOutput("rr_rdata", rdata, ((k - 3) % 2 == 0) ? 3'd1 : 3'd2);
            end
            if (k == 7) checkOutput("rr_rvalid_end", rvalid, 3'b000);
        end

        $display("[TB] single contour read");
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k == 0) ? 3'b010 : 3'b000, 3'b000, 19'd0, 19'd641, 19'd0, 3'd0, 3'd0, 3'd0);
            if (k == 0) checkOutput("rd_gnt", gnt, 3'b010);
            if (k == 1) begin
                checkOutput("rd_bram_addr", bram_addr, 19'd641);
                checkOutput("rd_bram_we", bram_we, 1'b0);
            end
            if (k == 2) checkOutput("rd_rvalid_early", rvalid, 3'b000);
            if (k == 3) begin
                checkOutput("rd_rvalid", rvalid, 3'b010);
                checkOutput("rd_rdata", rdata, 3'b101);
            end
            if (k == 4) checkOutput("rd_rvalid_once", rvalid, 3'b000);
        end

        $display("[TB] contention with starvation override");
        for (int k = 0; k < 32; k++) begin
            applyStimulus(3'b111, 3'b000, 19'd10, 19'd20, 19'd641, 3'd0, 3'd0, 3'd0);
            checkOutput($sformatf("starve_gnt_%0d", k), gnt,
                        (k == 15) ? 3'b001 : ((k == 31) ? 3'b010 : 3'b100));
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b000, 3'b000, 19'd0, 19'd0, 19'd0, 3'd0, 3'd0, 3'd0);
        end
        checkOutput("starve_drain", rvalid, 3'b000);

        $display("[TB] write then read same address");
        for (int k = 0; k < 6; k++) begin
            applyStimulus((k < 2) ? 3'b010 : 3'b000, (k == 0) ? 3'b010 : 3'b000,
                          19'd0, 19'd1000, 19'd0, 3'd0, 3'b011, 3'd0);
            if (k < 2) checkOutput("wr_gnt", gnt, 3'b010);
            if (k == 1) begin
                checkOutput("wr_bram_we", bram_we, 1'b1);
                checkOutput("wr_bram_addr", bram_addr, 19'd1000);
                checkOutput("wr_bram_din", bram_din, 3'b011);
            end
            if (k == 2) checkOutput("wr_read_we", bram_we, 1'b0);
            if (k == 3) checkOutput("wr_no_pulse", rvalid, 3'b000);
            if (k == 4) begin
                checkOutput("wr_rvalid", rvalid, 3'b010);
                checkOutput("wr_rdata", rdata, 3'b011);
            end
            if (k == 5) checkOutput("wr_rvalid_once", rvalid, 3'b000);
        end

        $display("[TB] out-of-range accesses");
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k == 0) ? 3'b010 : 3'b000, 3'b000, 19'd0, 19'h7FFFF, 19'd0, 3'd0, 3'd0, 3'd0);
            if (k == 0) begin
                checkOutput("oob_gnt", gnt, 3'b010);
                checkOutput("oob_err_before", addr_err, 1'b0);
            end
            if (k == 1) checkOutput("oob_err_set", addr_err, 1'b1);
            if (k == 3) begin
                checkOutput("oob_rvalid", rvalid, 3'b010);
                checkOutput("oob_rdata", rdata, 3'd0);
            end
        end
        applyStimulus(3'b001, 3'b001, 19'd307200, 19'd0, 19'd0, 3'd5, 3'd0, 3'd0);
        checkOutput("oob_wr_gnt", gnt, 3'b001);
        applyStimulus(3'b001, 3'b001, 19'd307199, 19'd0, 19'd0, 3'd4, 3'd0, 3'd0);
        checkOutput("oob_wr_gnt2", gnt, 3'b001);
        checkOutput("oob_wr_we", bram_we, 1'b0);
        checkOutput("oob_wr_addr", bram_addr, 19'd307200);
        applyStimulus(3'b000, 3'b000, 19'd0, 19'd0, 19'd0, 3'd0, 3'd0, 3'd0);
        checkOutput("max_wr_we", bram_we, 1'b1);
        checkOutput("max_wr_addr", bram_addr, 19'd307199);
        checkOutput("max_wr_din", bram_din, 3'd4);
        applyStimulus(3'b000, 3'b000, 19'd0, 19'd0, 19'd0, 3'd0, 3'd0, 3'd0);
        checkOutput("oob_err_sticky", addr_err, 1'b1);

        $display("[TB] reset during an in-flight read");
        applyStimulus(3'b100, 3'b000, 19'd20, 19'd20, 19'd641, 3'd1, 3'd1, 3'd1);
        checkOutput("mid_gnt", gnt, 3'b100);
        @(negedge clk);
        reset = 1'b1;
        req = 3'b111;
        we = 3'b111;
        #1;
        checkOutput("mid_rst_gnt", gnt, 3'b000);
        checkOutput("mid_rst_rvalid", rvalid, 3'b000);
        checkOutput("mid_rst_rdata", rdata, 3'd0);
        checkOutput("mid_rst_addr_err", addr_err, 1'b0);
        checkOutput("mid_rst_bram_addr", bram_addr, 19'd0);
        checkOutput("mid_rst_bram_we", bram_we, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("mid_rst_we_hold", bram_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        we = '0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b000, 3'b000, 19'd0, 19'd0, 19'd0, 3'd0, 3'd0, 3'd0);
            checkOutput("mid_no_rvalid", rvalid, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
